// File: rtl/mem_write_arbiter.sv
// Two-source write arbiter: per-source 4-entry skid FIFOs feeding one registered memory port.
// Optional per-frame consumed-word statistics are built when ARB_STATS_EN is defined.
module mem_write_arbiter #(
    parameter int MAX_BURST  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_flag,
    input  logic        ntsc_wr,
    input  logic [17:0] ntsc_pixel,
    input  logic [9:0]  ntsc_x,
    input  logic [8:0]  ntsc_y,
    output logic        ntsc_ok,
    input  logic        pt_wr,
    input  logic [17:0] pt_pixel_write,
    input  logic [9:0]  pt_x,
    input  logic [8:0]  pt_y,
    output logic        ptflag,
    input  logic        mem_busy,
    output logic        mem_wr,
    output logic [17:0] mem_pixel,
    output logic [9:0]  mem_x,
    output logic [8:0]  mem_y,
    output logic        mem_src,
    output logic [1:0]  ovf,
    output logic [18:0] ntsc_cnt,
    output logic [18:0] pt_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int DW = 37;

    typedef enum logic {IDLE, ISSUE} state_e;

    logic [1:0]         wr, push, pop, ne, ok_v, ovf_v;
    logic [1:0][DW-1:0] din, head;

    assign wr     = {pt_wr, ntsc_wr};
    assign din[0] = {ntsc_pixel, ntsc_x, ntsc_y};
    assign din[1] = {pt_pixel_write, pt_x, pt_y};
    assign push   = wr & ok_v;

    for (genvar s = 0; s < 2; s++) begin : g_src
        logic [DW-1:0] mem_q [FIFO_DEPTH];
        logic [PW-1:0] rp_q, wp_q;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          ok_q, ovf_q;

        assign ne[s]    = (cnt_q != '0);
        assign head[s]  = mem_q[rp_q];
        assign cnt_d    = cnt_q + CW'(push[s]) - CW'(pop[s]);
        assign ok_v[s]  = ok_q;
        assign ovf_v[s] = ovf_q;

        always_ff @(posedge clk) begin
            if (push[s]) mem_q[wp_q] <= din[s];
        end

        // ok looks at the post-update count so a word already in flight still fits
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rp_q  <= '0;
                wp_q  <= '0;
                cnt_q <= '0;
                ok_q  <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                if (push[s]) wp_q <= wp_q + PW'(1);
                if (pop[s])  rp_q <= rp_q + PW'(1);
                cnt_q <= cnt_d;
                ok_q  <= (cnt_d <= CW'(FIFO_DEPTH - 2));
                ovf_q <= ovf_q | (wr[s] & ~ok_q);
            end
        end
    end

    state_e        state_q, state_d;
    logic          load, consume, win;
    logic [DW-1:0] word_q;
    logic          src_q, last_q;
    logic [BW-1:0] burst_q;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        consume = (state_q == ISSUE) && !mem_busy;
        win     = ne[1];
        if (ne == 2'b11) win = (burst_q < BW'(MAX_BURST)) ? last_q : ~last_q;
        if (state_q == IDLE || consume) begin
            load    = |ne;
            state_d = (|ne) ? ISSUE : IDLE;
        end
    end

    assign pop = {load & win, load & ~win};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                word_q <= head[win];
                src_q  <= win;
            end
            if (frame_flag) begin
                last_q  <= 1'b0;
                burst_q <= '0;
            end else if (load) begin
                last_q <= win;
                if (win != last_q)                    burst_q <= BW'(1);
                else if (burst_q != BW'(MAX_BURST))   burst_q <= burst_q + BW'(1);
            end
        end
    end

    assign mem_wr                   = (state_q == ISSUE);
    assign {mem_pixel, mem_x, mem_y} = word_q;
    assign mem_src                  = src_q;
    assign ntsc_ok                  = ok_v[0];
    assign ptflag                   = ok_v[1];
    assign ovf                      = ovf_v;

`ifdef ARB_STATS_EN
    logic [1:0][18:0] stat_q, snap_q;

    // a word consumed on the frame_flag cycle belongs to the new frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_q <= '0;
            snap_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (frame_flag) begin
                    snap_q[s] <= stat_q[s];
                    stat_q[s] <= 19'(consume && (src_q == 1'(s)));
                end else if (consume && (src_q == 1'(s))) begin
                    stat_q[s] <= stat_q[s] + 19'd1;
                end
            end
        end
    end

    assign ntsc_cnt = snap_q[0];
    assign pt_cnt   = snap_q[1];
`else
    assign ntsc_cnt = '0;
    assign pt_cnt   = '0;
`endif

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed + randomized bench for mem_write_arbiter; per-source queues model accepted words.
module tb_mem_write_arbiter;
    localparam int MB = 8;
`ifdef ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1, frame_flag = 1'b0, mem_busy = 1'b0;
    logic ntsc_wr = 1'b0, pt_wr = 1'b0;
    logic [17:0] ntsc_pixel = '0, pt_pixel_write = '0;
    logic [9:0]  ntsc_x = '0, pt_x = '0;
    logic [8:0]  ntsc_y = '0, pt_y = '0;
    logic        ntsc_ok, ptflag, mem_wr, mem_src;
    logic [17:0] mem_pixel;
    logic [9:0]  mem_x;
    logic [8:0]  mem_y;
    logic [1:0]  ovf;
    logic [18:0] ntsc_cnt, pt_cnt;

    mem_write_arbiter #(.MAX_BURST(MB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .frame_flag(frame_flag),
        .ntsc_wr(ntsc_wr), .ntsc_pixel(ntsc_pixel), .ntsc_x(ntsc_x), .ntsc_y(ntsc_y), .ntsc_ok(ntsc_ok),
        .pt_wr(pt_wr), .pt_pixel_write(pt_pixel_write), .pt_x(pt_x), .pt_y(pt_y), .ptflag(ptflag),
        .mem_busy(mem_busy), .mem_wr(mem_wr), .mem_pixel(mem_pixel), .mem_x(mem_x), .mem_y(mem_y),
        .mem_src(mem_src), .ovf(ovf), .ntsc_cnt(ntsc_cnt), .pt_cnt(pt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [37:0] got_q[$];
    logic [36:0] exp_n[$], exp_p[$];
    int gi = 0;
    logic [1:0] exp_ovf = '0;
    int run_len = 0, max_run = 0, hold_err = 0;
    logic last_src = 1'b0, prev_hold = 1'b0;
    logic [37:0] prev_word = '0;
    bit phase = 1'b0;

    // observe memory side: consumed words, grant runs, hold-while-busy
    always @(negedge clk) begin
        if (reset) begin
            run_len   = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && (mem_wr !== 1'b1 || {mem_src, mem_pixel, mem_x, mem_y} !== prev_word))
                hold_err++;
            prev_hold = mem_wr && mem_busy;
            prev_word = {mem_src, mem_pixel, mem_x, mem_y};
            if (mem_wr && !mem_busy) begin
                got_q.push_back({mem_src, mem_pixel, mem_x, mem_y});
                run_len  = (run_len != 0 && mem_src == last_src) ? run_len + 1 : 1;
                last_src = mem_src;
                if (phase && run_len > max_run) max_run = run_len;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit nw, input bit pw);
        ntsc_wr        = nw && ntsc_ok;
        pt_wr          = pw && ptflag;
        ntsc_pixel     = 18'($urandom);
        ntsc_x         = 10'($urandom);
        ntsc_y         = 9'($urandom);
        pt_pixel_write = 18'($urandom);
        pt_x           = 10'($urandom);
        pt_y           = 9'($urandom);
        if (ntsc_wr) exp_n.push_back({ntsc_pixel, ntsc_x, ntsc_y});
        if (pt_wr)   exp_p.push_back({pt_pixel_write, pt_x, pt_y});
        tick();
        ntsc_wr = 1'b0;
        pt_wr   = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        mem_busy = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        exp_n.delete();
        exp_p.delete();
        exp_ovf = '0;
        gi = got_q.size();
        tick();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        int want = exp_n.size() + exp_p.size();
        logic [37:0] w;
        logic [36:0] e;
        while (got_q.size() - gi < want && n < 400) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk({tag, "_count"}, 64'(got_q.size() - gi), 64'(want));
        while (gi < got_q.size()) begin
            w = got_q[gi];
            gi++;
            e = 'x;
            if (w[37]) begin
                if (exp_p.size() != 0) e = exp_p.pop_front();
            end else begin
                if (exp_n.size() != 0) e = exp_n.pop_front();
            end
            chk({tag, "_word"}, 64'(w[36:0]), 64'(e));
        end
        exp_n.delete();
        exp_p.delete();
    endtask

    initial begin
        int pacc, n0, nn, pp, a0, b0, it;

        repeat (3) tick();
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_pixel", mem_pixel, 0);
        chk("rst_x", mem_x, 0);
        chk("rst_y", mem_y, 0);
        chk("rst_src", mem_src, 0);
        chk("rst_ntsc_ok", ntsc_ok, 0);
        chk("rst_ptflag", ptflag, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ntsc_cnt", ntsc_cnt, 0);
        chk("rst_pt_cnt", pt_cnt, 0);
        reset = 1'b0;
        chk("ok_before_edge", ntsc_ok, 0);
        tick();
        chk("ntsc_ok_rise", ntsc_ok, 1);
        chk("ptflag_rise", ptflag, 1);

        // single pt word, two-cycle latency
        pt_wr = 1'b1; pt_pixel_write = 18'h2AAAA; pt_x = 10'd5; pt_y = 9'd7;
        exp_p.push_back({18'h2AAAA, 10'd5, 9'd7});
        tick();
        pt_wr = 1'b0;
        chk("lat_n0_wr", mem_wr, 0);
        tick();
        chk("lat_wr", mem_wr, 1);
        chk("lat_pixel", mem_pixel, 18'h2AAAA);
        chk("lat_x", mem_x, 5);
        chk("lat_y", mem_y, 7);
        chk("lat_src", mem_src, 1);
        tick();
        chk("lat_done", mem_wr, 0);
        chk("lat_ovf", ovf, 0);
        drain("single");

        // both sources saturating
        do_reset();
        phase = 1'b1;
        repeat (200) step(1'b1, 1'b1);
        phase = 1'b0;
        drain("burst");
        chk("burst_max_run", max_run, MB);
        chk("burst_ovf", ovf, 0);

        // random traffic with random backpressure
        repeat (300) begin
            mem_busy = ($urandom_range(0, 3) == 0);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        mem_busy = 1'b0;
        drain("random");
        chk("random_ovf", ovf, 0);

        // backpressure: output holds a capture word, pt fills its FIFO
        do_reset();
        mem_busy = 1'b1;
        step(1'b1, 1'b0);
        tick();
        chk("busy_wr", mem_wr, 1);
        chk("busy_src", mem_src, 0);
        pacc = 0;
        repeat (10) begin
            if (ptflag) pacc++;
            step(1'b0, 1'b1);
        end
        chk("busy_pt_accepted", pacc, 3);
        chk("busy_ptflag_low", ptflag, 0);
        pt_wr = 1'b1; pt_pixel_write = 18'h3FFFF; pt_x = 10'h3FF; pt_y = 9'h1FF;
        if (!ptflag) exp_ovf[1] = 1'b1;
        tick();
        pt_wr = 1'b0;
        chk("drop_ovf", ovf, exp_ovf);
        chk("drop_hold_wr", mem_wr, 1);
        chk("drop_hold_src", mem_src, 0);
        mem_busy = 1'b0;
        drain("busy_drain");
        chk("ovf_sticky", ovf, exp_ovf);

        // reset mid-transfer
        do_reset();
        chk("ovf_cleared", ovf, 0);
        mem_busy = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        tick();
        chk("abort_pre_wr", mem_wr, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_wr_low", mem_wr, 0);
        chk("abort_ok_low", ntsc_ok, 0);
        tick();
        reset = 1'b0;
        mem_busy = 1'b0;
        exp_n.delete();
        exp_p.delete();
        n0 = got_q.size();
        repeat (10) tick();
        chk("abort_no_stale", got_q.size(), n0);
        chk("abort_idle", mem_wr, 0);
        gi = got_q.size();

        // per-frame statistics
        do_reset();
        nn = 0; pp = 0; it = 0;
        while ((nn < 100 || pp < 37) && it < 3000) begin
            mem_busy = ($urandom_range(0, 4) == 0);
            a0 = exp_n.size();
            b0 = exp_p.size();
            step(nn < 100 && $urandom_range(0, 1) == 1, pp < 37 && $urandom_range(0, 2) == 0);
            nn += exp_n.size() - a0;
            pp += exp_p.size() - b0;
            it++;
        end
        mem_busy = 1'b0;
        drain("stats");
        frame_flag = 1'b1;
        tick();
        frame_flag = 1'b0;
        chk("stats_ntsc_cnt", ntsc_cnt, STATS ? 100 : 0);
        chk("stats_pt_cnt", pt_cnt, STATS ? 37 : 0);
        frame_flag = 1'b1;
        tick();
        frame_flag = 1'b0;
        chk("stats_ntsc_clear", ntsc_cnt, 0);
        chk("stats_pt_clear", pt_cnt, 0);

        chk("hold_while_busy", hold_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
